seq_det_ctrl: RTL and testbench
===============================

# seq_det_ctrl

Programmable serial sequence-detector controller. It accepts a pattern configuration through a valid/ready handshake, arms on `start`, and samples a qualified serial bit stream. For each match it produces a Moore-style registered pulse and keeps a match count; it stops with `done` once a programmed target count is reached. It sits in front of the serial datapath and replaces hard-coded fixed-pattern detectors, such as the 11011 overlap/non-overlap variants.

## Interface
- `PAT_W`, 5: maximum pattern length in bits (≥2).
- `CNT_W`, 8: width of the match counter and target.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `cfg_valid` input 1: configuration offered.
- `cfg_ready` output 1: configuration can be accepted.
- `cfg_pattern` input PAT_W: pattern; bit `[len-1]` is the first bit received, bit `[0]` is the last.
- `cfg_len` input 4: pattern length; legal values 1..PAT_W.
- `cfg_overlap` input 1: 1 = overlapping detection, 0 = non-overlapping.
- `cfg_target` input CNT_W: number of matches before `done`; 0 = run until `abort`.
- `cfg_err` output 1: one-cycle pulse when an illegal config is rejected.
- `start` input 1: begin a detection run.
- `abort` input 1: stop the current run.
- `in_valid` input 1: `in` is sampled this cycle.
- `in` input 1: serial data bit.
- `out` output 1: one-cycle match pulse.
- `match_count` output CNT_W: matches in the current run.
- `busy` output 1: high in RUN.
- `done` output 1: high in DONE.

## Operation
- States:
  - IDLE: no valid config.
  - ARMED: config held.
  - RUN: sampling.
  - DONE: target reached.
- `cfg_ready` = 1 in IDLE, ARMED and DONE; 0 in RUN. It is combinational from state.
- Config handshake: `cfg_valid & cfg_ready`.
  - Legal `cfg_len`: store pattern, len, overlap and target, then go to ARMED.
  - `cfg_len`=0 or >PAT_W: nothing is stored, `cfg_err` pulses, state unchanged.
  - A legal config accepted in DONE goes to ARMED; `match_count` is retained.
- `start` in ARMED or DONE goes to RUN and clears `hist`, `fill` and `match_count`. `start` in IDLE or RUN is ignored.
- Priority order: `abort` > config handshake > `start`. A config handshake and `start` in the same cycle: config is accepted, `start` is dropped.
- `abort` in RUN or DONE goes to ARMED; `fill` is cleared and `match_count` is held. `abort` in IDLE or ARMED has no effect.
- RUN, on each cycle with `in_valid`=1:
  - `hist <= {hist[PAT_W-2:0], in}`.
  - `fill` increments, saturating at PAT_W.
  - The match condition is evaluated on the updated values: `fill ≥ len` and `hist[len-1:0] == pattern[len-1:0]`.
- Cycles with `in_valid`=0 leave `hist` and `fill` unchanged; gaps are transparent.
- On a match:
  - `out` pulses.
  - `match_count` increments, saturating at all-ones.
  - Non-overlap mode: `fill` is forced to 0 (the bits are consumed).
  - Overlap mode: `fill` stays saturated.
- If `cfg_target` ≠ 0 and the incremented count equals `cfg_target`, go to DONE. No further bits are sampled until `start`.
- Bits above `len` in `hist` and `pattern` are don't-care.

## Timing
- On reset assertion, immediately and asynchronously:
  - state = IDLE.
  - `out`, `busy`, `done`, `cfg_err` and `match_count` = 0.
  - `cfg_ready` = 1.
  - Stored config, `hist` and `fill` = 0.
- Reset takes effect mid-run with no completion of the pending match.
- `out` is registered. It is high for exactly the cycle after the edge that samples the last pattern bit. There is no combinational path from `in` to `out`.
- `match_count` updates on the same edge that raises `out`.
- When the target is reached, `done` rises and `busy` falls on that same edge.
- `busy` rises on the edge after `start` is accepted. The first bit can be sampled on the following edge.
- `cfg_err` is high for the cycle after the rejected handshake edge.
- Back-to-back matches produce back-to-back `out` pulses, e.g. overlap with len 1.

## Test plan
- Overlap, pattern 11011, len 5, target 0, stream 1,1,0,1,1,0,1,1 (`in_valid`=1 throughout) → `out` pulses after bit 5 and after bit 8; `match_count`=2.
- Same stream, non-overlap → single pulse after bit 5; `match_count`=1 at end.
- Non-overlap, target 2, stream 11011 11011 0 1 1 → `done`=1 and `busy`=0 after bit 10; trailing bits are ignored; `match_count` stays 2.
- `cfg_len`=0, then `cfg_len`=6 (PAT_W=5) → `cfg_err` pulses twice, state stays IDLE, `cfg_ready`=1, `start` is ignored.
- Pattern 11011 with `in_valid` gaps: bits 1,1, three idle cycles, then 0,1,1 → exactly one `out` pulse, after the final bit.
- `rst` driven low mid-RUN with `match_count`=3 → all outputs return to reset values without waiting for a clock edge. After `rst` deasserts, `start` is ignored until a new config is accepted.

Source files
------------

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: programmable serial sequence detector.
// A configuration (pattern, length, overlap mode, target count) is taken over a
// valid/ready handshake; `start` arms a run that shifts qualified serial bits
// into a history register and raises a registered one-cycle `out` pulse per match.
// The run ends in DONE once the programmed number of matches is seen (target 0
// means run until `abort`).
module seq_det_ctrl #(
  parameter int PAT_W = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,          // asynchronous, active-low
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [3:0]       cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  output logic             cfg_err,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic             in,
  output logic             out,
  output logic [CNT_W-1:0] match_count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Length and fill share the 4-bit width of cfg_len, so PAT_W must stay <= 15.
  localparam logic [3:0]       PAT_W_L = 4'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e state_q, state_d;

  // Stored configuration
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [3:0]       len_q, len_d;
  logic             ovl_q, ovl_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;

  // Datapath state
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [3:0]       fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             err_q, err_d;

  // Decoded events for this cycle
  logic             cfg_fire;
  logic             cfg_legal;
  logic             abort_hit;
  logic             cfg_take;
  logic             cfg_rej;
  logic             start_hit;
  logic             sample;

  // Candidate values if the current bit is sampled
  logic [PAT_W-1:0] hist_n;
  logic [3:0]       fill_n;
  logic [PAT_W-1:0] len_mask;
  logic             match;
  logic [CNT_W-1:0] cnt_inc;
  logic             reach;

  // Only the low len bits of history/pattern take part in the comparison.
  for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
    assign len_mask[gi] = (len_q > 4'(gi));
  end

  // Event decode: abort outranks a config handshake, which outranks start.
  always_comb begin
    cfg_fire  = cfg_valid & cfg_ready;
    cfg_legal = (cfg_len != 4'd0) && (cfg_len <= PAT_W_L);
    abort_hit = abort && ((state_q == S_RUN) || (state_q == S_DONE));
    cfg_take  = !abort_hit && cfg_fire && cfg_legal;
    cfg_rej   = !abort_hit && cfg_fire && !cfg_legal;
    start_hit = !abort_hit && !cfg_fire && start &&
                ((state_q == S_ARMED) || (state_q == S_DONE));
    sample    = !abort_hit && (state_q == S_RUN) && in_valid;
  end

  // Match evaluation on the values the sampling edge would produce.
  always_comb begin
    hist_n  = {hist_q[PAT_W-2:0], in};
    fill_n  = (fill_q == PAT_W_L) ? fill_q : fill_q + 4'd1;
    match   = sample && (fill_n >= len_q) &&
              (((hist_n ^ pat_q) & len_mask) == '0);
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
    reach   = match && (tgt_q != '0) && (cnt_inc == tgt_q);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_take) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (cfg_take)       state_d = S_ARMED;
        else if (start_hit) state_d = S_RUN;
      end
      S_RUN: begin
        if (abort_hit)  state_d = S_ARMED;
        else if (reach) state_d = S_DONE;
      end
      S_DONE: begin
        if (abort_hit)      state_d = S_ARMED;
        else if (cfg_take)  state_d = S_ARMED;
        else if (start_hit) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: status flags are decoded straight from the state.
  always_comb begin
    cfg_ready = (state_q != S_RUN);
    busy      = (state_q == S_RUN);
    done      = (state_q == S_DONE);
  end

  // Datapath next-state: config capture, run clearing, bit sampling and matching.
  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    tgt_d  = tgt_q;
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    out_d  = 1'b0;
    err_d  = cfg_rej;

    if (cfg_take) begin
      pat_d = cfg_pattern;
      len_d = cfg_len;
      ovl_d = cfg_overlap;
      tgt_d = cfg_target;
    end

    if (start_hit) begin
      hist_d = '0;
      fill_d = 4'd0;
      cnt_d  = '0;
    end

    // Abort keeps the count visible but forgets any partially received bits.
    if (abort_hit) begin
      fill_d = 4'd0;
    end

    if (sample) begin
      hist_d = hist_n;
      fill_d = fill_n;
      if (match) begin
        out_d = 1'b1;
        cnt_d = cnt_inc;
        // Non-overlap: the matched bits are consumed and cannot start a new match.
        if (!ovl_q) fill_d = 4'd0;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q  <= '0;
      len_q  <= 4'd0;
      ovl_q  <= 1'b0;
      tgt_q  <= '0;
      hist_q <= '0;
      fill_q <= 4'd0;
      cnt_q  <= '0;
      out_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      tgt_q  <= tgt_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      err_q  <= err_d;
    end
  end

  assign out         = out_q;
  assign cfg_err     = err_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Testbench for seq_det_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a queue-based behavioural model.
module tb_seq_det_ctrl;

  localparam int PAT_W = 5;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pattern;
  logic [3:0]       cfg_len;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_target;
  logic             cfg_err;
  logic             start;
  logic             abort;
  logic             in_valid;
  logic             din;
  logic             out;
  logic [CNT_W-1:0] match_count;
  logic             busy;
  logic             done;

  seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_target  (cfg_target),
    .cfg_err     (cfg_err),
    .start       (start),
    .abort       (abort),
    .in_valid    (in_valid),
    .in          (din),
    .out         (out),
    .match_count (match_count),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int pulses  = 0;
  int errs    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // States: 0 idle, 1 armed, 2 run, 3 done. `win` holds the bits received since
  // the last point where history became irrelevant (start, abort, consumed match).
  int       m_state;
  bit [4:0] m_pat;
  int       m_len;
  bit       m_ovl;
  int       m_tgt;
  int       m_cnt;
  bit       m_out;
  bit       m_err;
  bit       win[$];

  task automatic model_reset();
    m_state = 0; m_pat = 0; m_len = 0; m_ovl = 0; m_tgt = 0;
    m_cnt = 0; m_out = 0; m_err = 0;
    win.delete();
  endtask

  task automatic model_step(input bit cv, input bit [4:0] pat, input int len, input bit ovl,
                            input int tgt, input bit st, input bit ab, input bit iv, input bit d);
    bit ab_hit;
    bit hit;
    m_out  = 0;
    m_err  = 0;
    ab_hit = ab && (m_state == 2 || m_state == 3);
    if (ab_hit) begin
      m_state = 1;
      win.delete();
    end else if (cv && m_state != 2) begin
      if (len >= 1 && len <= PAT_W) begin
        m_pat = pat; m_len = len; m_ovl = ovl; m_tgt = tgt;
        m_state = 1;
      end else begin
        m_err = 1;
      end
    end else if (st && (m_state == 1 || m_state == 3)) begin
      m_state = 2;
      m_cnt   = 0;
      win.delete();
    end else if (m_state == 2 && iv) begin
      win.push_back(d);
      if (win.size() > PAT_W) void'(win.pop_front());
      hit = (win.size() >= m_len);
      if (hit) begin
        for (int k = 0; k < m_len; k++)
          if (win[win.size() - m_len + k] != m_pat[m_len - 1 - k]) hit = 0;
      end
      if (hit) begin
        m_out = 1;
        if (m_cnt < 255) m_cnt++;
        if (!m_ovl) win.delete();
        if (m_tgt != 0 && m_cnt == m_tgt) m_state = 3;
      end
    end
  endtask

  task automatic check_model(input string ph);
    check_eq({ph, ".out"},   32'(out),         32'(m_out));
    check_eq({ph, ".cnt"},   32'(match_count), 32'(m_cnt));
    check_eq({ph, ".busy"},  32'(busy),        32'(m_state == 2));
    check_eq({ph, ".done"},  32'(done),        32'(m_state == 3));
    check_eq({ph, ".ready"}, 32'(cfg_ready),   32'(m_state != 2));
    check_eq({ph, ".err"},   32'(cfg_err),     32'(m_err));
  endtask

  // One clock of stimulus; the model advances with the same inputs and is compared
  // 1 time unit after the edge.
  task automatic step(input bit cv, input bit [4:0] pat, input bit [3:0] len, input bit ovl,
                      input bit [7:0] tgt, input bit st, input bit ab, input bit iv,
                      input bit d, input string ph);
    cfg_valid = cv; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; cfg_target = tgt;
    start = st; abort = ab; in_valid = iv; din = d;
    @(posedge clk);
    #1;
    model_step(cv, pat, int'(len), ovl, int'(tgt), st, ab, iv, d);
    check_model(ph);
    if (out) pulses++;
    if (cfg_err) errs++;
    if (cv || st || ab || out)
      $display("[%0t] %s cv=%0b pat=%b len=%0d ovl=%0b tgt=%0d st=%0b ab=%0b out=%0b cnt=%0d busy=%0b done=%0b err=%0b",
               $time, ph, cv, pat, len, ovl, tgt, st, ab, out, match_count, busy, done, cfg_err);
  endtask

  task automatic idle(input int n, input string ph);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0, ph);
  endtask

  task automatic cfg(input bit [4:0] pat, input bit [3:0] len, input bit ovl,
                     input bit [7:0] tgt, input string ph);
    step(1, pat, len, ovl, tgt, 0, 0, 0, 0, ph);
  endtask

  task automatic go(input string ph);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, ph);
  endtask

  task automatic abrt(input string ph);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, ph);
  endtask

  task automatic bit_in(input bit d, input string ph);
    step(0, 0, 0, 0, 0, 0, 0, 1, d, ph);
  endtask

  task automatic feed(input bit [15:0] bits, input int n, input string ph);
    for (int i = n - 1; i >= 0; i--) bit_in(bits[i], ph);
  endtask

  initial begin
    rst = 1'b0;
    cfg_valid = 0; cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0; cfg_target = 0;
    start = 0; abort = 0; in_valid = 0; din = 0;
    model_reset();
    #12;
    check_eq("rst.out",   32'(out), 0);
    check_eq("rst.cnt",   32'(match_count), 0);
    check_eq("rst.busy",  32'(busy), 0);
    check_eq("rst.done",  32'(done), 0);
    check_eq("rst.ready", 32'(cfg_ready), 1);
    check_eq("rst.err",   32'(cfg_err), 0);
    rst = 1'b1;

    // Illegal lengths are rejected from IDLE; start is then ignored.
    errs = 0;
    cfg(5'b11011, 4'd0, 0, 0, "tp4");
    check_eq("tp4.err0", 32'(cfg_err), 1);
    idle(1, "tp4");
    cfg(5'b11011, 4'd6, 0, 0, "tp4");
    check_eq("tp4.err6", 32'(cfg_err), 1);
    go("tp4");
    check_eq("tp4.busy", 32'(busy), 0);
    check_eq("tp4.ready", 32'(cfg_ready), 1);
    check_eq("tp4.errs", 32'(errs), 2);

    // Overlap 11011 over 11011011: two matches.
    cfg(5'b11011, 4'd5, 1, 0, "tp1");
    go("tp1");
    check_eq("tp1.busy", 32'(busy), 1);
    pulses = 0;
    feed(16'b11011011, 8, "tp1");
    check_eq("tp1.pulses", 32'(pulses), 2);
    check_eq("tp1.cnt", 32'(match_count), 2);

    // Same stream, non-overlap: one match.
    abrt("tp2");
    cfg(5'b11011, 4'd5, 0, 0, "tp2");
    go("tp2");
    pulses = 0;
    feed(16'b11011011, 8, "tp2");
    check_eq("tp2.pulses", 32'(pulses), 1);
    check_eq("tp2.cnt", 32'(match_count), 1);

    // Non-overlap, target 2: DONE after bit 10, trailing bits ignored.
    abrt("tp3");
    cfg(5'b11011, 4'd5, 0, 8'd2, "tp3");
    go("tp3");
    pulses = 0;
    feed(16'b1101111011, 10, "tp3");
    check_eq("tp3.done", 32'(done), 1);
    check_eq("tp3.busy", 32'(busy), 0);
    feed(16'b011, 3, "tp3");
    check_eq("tp3.cnt", 32'(match_count), 2);
    check_eq("tp3.pulses", 32'(pulses), 2);

    // Gaps in in_valid are transparent.
    abrt("tp5");
    cfg(5'b11011, 4'd5, 1, 0, "tp5");
    go("tp5");
    pulses = 0;
    bit_in(1, "tp5"); bit_in(1, "tp5");
    idle(3, "tp5");
    bit_in(0, "tp5"); bit_in(1, "tp5"); bit_in(1, "tp5");
    check_eq("tp5.last", 32'(out), 1);
    check_eq("tp5.pulses", 32'(pulses), 1);

    // Overlap len 1: back-to-back pulses, then asynchronous reset mid-run.
    abrt("tp6");
    cfg(5'b00001, 4'd1, 1, 0, "tp6");
    go("tp6");
    feed(16'b111, 3, "tp6");
    check_eq("tp6.cnt3", 32'(match_count), 3);
    #1 rst = 1'b0;
    #1;
    check_eq("tp6.rout",   32'(out), 0);
    check_eq("tp6.rcnt",   32'(match_count), 0);
    check_eq("tp6.rbusy",  32'(busy), 0);
    check_eq("tp6.rdone",  32'(done), 0);
    check_eq("tp6.rready", 32'(cfg_ready), 1);
    check_eq("tp6.rerr",   32'(cfg_err), 0);
    model_reset();
    #1 rst = 1'b1;
    go("tp6");
    check_eq("tp6.nostart", 32'(busy), 0);
    bit_in(1, "tp6");

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) == 0, 5'($urandom), 4'($urandom_range(0, 6)),
           1'($urandom), 8'($urandom_range(0, 4)), $urandom_range(0, 11) == 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 1'($urandom), "rnd");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
